// File: rtl/key_schedule_if.sv
// Bus between the RC4 key-schedule engine and its environment: run request,
// key, completion flag and the S RAM port.
interface key_schedule_if;
  // start/finish is a level request/acknowledge pair: start held high in idle
  // begins a run, finish rises when S is complete and stays high while start
  // is held, and dropping start returns the engine to idle. The S RAM port has
  // no handshake: one write per cycle that write_enable is high, and read data
  // follows a registered address.
  logic        start;
  logic [23:0] secret_key;
  logic        finish;
  logic [7:0]  s_memory_address;
  logic [7:0]  s_memory_data;
  logic        s_memory_write_enable;
  logic [7:0]  s_memory_q;

  modport master (
    output start, secret_key, s_memory_q,
    input  finish, s_memory_address, s_memory_data, s_memory_write_enable
  );

  modport slave (
    input  start, secret_key, s_memory_q,
    output finish, s_memory_address, s_memory_data, s_memory_write_enable
  );
endinterface

// File: rtl/key_schedule.sv
// RC4 key-scheduling engine: fills S with 0..255, then performs the 256 KSA
// swaps against an external S RAM with one cycle of read latency.
module key_schedule (
    input  logic          clk,
    input  logic          reset,
    key_schedule_if.slave bus,
    output logic [3:0]    dbg_state
);

    typedef enum logic [3:0] {
        IDLE, INIT, RD_I, WAIT_I, RD_J, WAIT_J, WR_I, WR_J, DONE
    } state_t;

    state_t      state;
    logic [7:0]  i;
    logic [7:0]  j;
    logic [7:0]  si;
    logic [1:0]  i_mod3;
    logic [23:0] key;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic        we;
    logic        fin;
    logic [7:0]  key_byte;
    logic [7:0]  j_next;

    always_comb begin
        key_byte = key[23:16];
        case (i_mod3)
            2'd1:    key_byte = key[15:8];
            2'd2:    key_byte = key[7:0];
            default: key_byte = key[23:16];
        endcase
    end

    // q holds S[i] during WAIT_I because the address was presented in RD_I.
    assign j_next = j + bus.s_memory_q + key_byte;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            i      <= 8'd0;
            j      <= 8'd0;
            si     <= 8'd0;
            i_mod3 <= 2'd0;
            key    <= 24'd0;
            addr   <= 8'd0;
            data   <= 8'd0;
            we     <= 1'b0;
            fin    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    we  <= 1'b0;
                    fin <= 1'b0;
                    if (bus.start) begin
                        state  <= INIT;
                        i      <= 8'd0;
                        j      <= 8'd0;
                        i_mod3 <= 2'd0;
                        key    <= bus.secret_key;
                        addr   <= 8'd0;
                        data   <= 8'd0;
                        we     <= 1'b1;
                    end
                end
                INIT: begin
                    if (i == 8'hff) begin
                        state  <= RD_I;
                        i      <= 8'd0;
                        i_mod3 <= 2'd0;
                        addr   <= 8'd0;
                        we     <= 1'b0;
                    end else begin
                        i    <= i + 8'd1;
                        addr <= i + 8'd1;
                        data <= i + 8'd1;
                        we   <= 1'b1;
                    end
                end
                RD_I: state <= WAIT_I;
                WAIT_I: begin
                    si    <= bus.s_memory_q;
                    j     <= j_next;
                    addr  <= j_next;
                    state <= RD_J;
                end
                RD_J: state <= WAIT_J;
                WAIT_J: begin
                    // q now holds S[j]; it is written straight back to S[i].
                    addr  <= i;
                    data  <= bus.s_memory_q;
                    we    <= 1'b1;
                    state <= WR_I;
                end
                WR_I: begin
                    addr  <= j;
                    data  <= si;
                    we    <= 1'b1;
                    state <= WR_J;
                end
                WR_J: begin
                    we <= 1'b0;
                    if (i == 8'hff) begin
                        state <= DONE;
                        fin   <= 1'b1;
                        addr  <= 8'd0;
                        data  <= 8'd0;
                    end else begin
                        i      <= i + 8'd1;
                        i_mod3 <= (i_mod3 == 2'd2) ? 2'd0 : i_mod3 + 2'd1;
                        addr   <= i + 8'd1;
                        state  <= RD_I;
                    end
                end
                DONE: begin
                    we <= 1'b0;
                    if (!bus.start) begin
                        state <= IDLE;
                        fin   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    we    <= 1'b0;
                    fin   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_memory_address      = addr;
    assign bus.s_memory_data         = data;
    assign bus.s_memory_write_enable = we;
    assign bus.finish                = fin;
    assign dbg_state                 = state;

endmodule
